wallace_gen: RTL and testbench
==============================

# wallace_gen

Pipelined signed two's-complement multiplier that multiplies an N-bit operand by a W-bit operand using Baugh-Wooley partial products and a Wallace-tree carry-save reduction. It ends in a single carry-propagate adder and a registered result. It is the multiply primitive for the CNN MAC datapath, sitting between the operand fetch logic and the accumulator.

## Interface
Parameters:
- N, default 8: width of operand `a`. N ≥ W is required.
- W, default 5: width of operand `b`. 2 ≤ W ≤ N is required.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  operands valid this cycle
- a  input  N  signed multiplicand (two's complement)
- b  input  W  signed multiplier (two's complement)
- out_vld  output  1  `prod` holds the result of a valid operand pair
- prod  output  N+W-1  low N+W-1 bits of a × b, two's complement

## Operation
- Partial products use the Baugh-Wooley scheme:
  - W rows of N bits: bit (i,j) = a[j]&b[i].
  - Sign-bit terms are inverted for rows/columns involving exactly one of a[N-1], b[W-1].
  - Correction constants are added at columns N-1, W-1 and N+W-1.
- Reduction: columns are compressed with full and half adders, Wallace style, until at most 2 bits remain per column. A final ripple or prefix adder then produces the sum.
- Arithmetic result: prod = (signed(a) × signed(b)) mod 2^(N+W-1). Only the low N+W-1 bits are kept and bit N+W-1 is discarded.
- Boundary case a = −2^(N-1), b = −2^(W-1): the true product is +2^(N+W-2). `prod` shows it as 1 followed by N+W-2 zeros, which reads as a negative number. This wrap is required behaviour and must not be saturated.
- Every other operand pair produces the exact signed product.
- No internal state beyond the pipeline registers. Operands are consumed only in cycles where in_vld=1.

## Timing
- Latency is 1 cycle. The cycle after in_vld=1 with operands a, b, the outputs show out_vld=1 and the product of a, b.
- Throughput is one operation per cycle. Back-to-back in_vld=1 yields back-to-back results.
- When in_vld=0, out_vld goes to 0 next cycle and `prod` holds its previous value.
- Reset:
  - Reset values are prod=0 and out_vld=0.
  - Reset asserted mid-stream clears both immediately, without waiting for a clock edge. The in-flight result is dropped.
  - The first valid result after release appears 1 cycle after the first in_vld=1.
- There is no backpressure; the downstream logic must accept every out_vld pulse.

## Configuration
- Macro WALLACE_GEN_IN_REG_EN.
  - Defined: a, b and in_vld are registered before the partial-product stage (reset to 0), and latency becomes 2 cycles.
  - Undefined: inputs feed the tree combinationally, and latency is 1 cycle.
  - Arithmetic is identical in both builds.

## Test plan
Default N=8, W=5, WALLACE_GEN_IN_REG_EN undefined:
- Exhaustive sweep of all 2^13 (a, b) pairs, in_vld=1 every cycle. Each prod must equal the low 12 bits of the signed product, one cycle later, with out_vld=1 throughout.
- Directed values:
  - a=5, b=3 → prod=0x00F.
  - a=0xFF (−1), b=1 → 0xFFF.
  - a=0xFD (−3), b=0x1B (−5) → 0x00F.
  - a=127, b=15 → 0x771.
  - a=127, b=0x10 (−16) → 0x810.
- Corner case: a=0x80, b=0x10 → prod=0x800 (wrapped +2048), never saturated.
- Valid gating: in_vld pattern 1,0,1. out_vld must read 1,0,1 one cycle later, and prod must hold its previous value in the idle cycle.
- Reset: assert rst_n=0 between clock edges while out_vld=1. prod=0 and out_vld=0 must appear immediately. After release, the first result comes 1 cycle after in_vld.
- Build with WALLACE_GEN_IN_REG_EN defined and repeat the sweep. Results must be identical, with 2-cycle latency.

Source files
------------

// File: rtl/wallace_gen.sv
// Pipelined signed N x W multiplier: Baugh-Wooley partial products, Wallace carry-save tree, registered result.
// Define WALLACE_GEN_IN_REG_EN to register a, b and in_vld ahead of the tree (latency 2 instead of 1).
module wallace_gen #(
    parameter int N = 8,
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    input  logic [N-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_vld,
    output logic [N+W-2:0] prod
);
    localparam int PC     = N + W - 1;
    localparam int H      = W + 3;
    localparam int STAGES = W + 2;

    // Valid semantics: a/b are consumed only in cycles with in_vld=1; each such cycle yields
    // exactly one out_vld pulse a fixed latency later. There is no ready: the consumer must take every pulse.
    logic         op_vld;
    logic [N-1:0] op_a;
    logic [W-1:0] op_b;

`ifdef WALLACE_GEN_IN_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_vld <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            op_vld <= in_vld;
            if (in_vld) begin
                op_a <= a;
                op_b <= b;
            end
        end
    end
`else
    assign op_vld = in_vld;
    assign op_a   = a;
    assign op_b   = b;
`endif

    logic [H-1:0]  m   [PC];
    logic [H-1:0]  nm  [PC];
    int            ht  [PC];
    int            nht [PC];
    int            maxh;
    logic [H-1:0]  sh;
    logic          pp;
    logic          x0;
    logic          x1;
    logic          x2;
    logic [PC-1:0] row_x;
    logic [PC-1:0] row_y;
    logic [PC-1:0] sum;

    // Column heights depend only on N and W, so every shift by ht/nht folds to wiring.
    always_comb begin
        for (int c = 0; c < PC; c++) begin
            m[c]   = '0;
            nm[c]  = '0;
            ht[c]  = 0;
            nht[c] = 0;
        end
        maxh  = 0;
        sh    = '0;
        pp    = 1'b0;
        x0    = 1'b0;
        x1    = 1'b0;
        x2    = 1'b0;
        row_x = '0;
        row_y = '0;

        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < N; j++) begin
                pp = op_a[j] & op_b[i];
                if ((i == W - 1) != (j == N - 1)) pp = ~pp;
                m[i+j]  = m[i+j] | (H'(pp) << ht[i+j]);
                ht[i+j] = ht[i+j] + 1;
            end
        end
        // The third correction bit lands at column N+W-1, which is truncated away.
        m[W-1]  = m[W-1] | (H'(1'b1) << ht[W-1]);
        ht[W-1] = ht[W-1] + 1;
        m[N-1]  = m[N-1] | (H'(1'b1) << ht[N-1]);
        ht[N-1] = ht[N-1] + 1;

        for (int s = 0; s < STAGES; s++) begin
            maxh = 0;
            for (int c = 0; c < PC; c++) begin
                if (ht[c] > maxh) maxh = ht[c];
            end
            if (maxh > 2) begin
                for (int c = 0; c < PC; c++) begin
                    nm[c]  = '0;
                    nht[c] = 0;
                end
                for (int c = 0; c < PC; c++) begin
                    for (int g = 0; g < H; g += 3) begin
                        sh = m[c] >> g;
                        x0 = sh[0];
                        x1 = sh[1];
                        x2 = sh[2];
                        if (ht[c] - g >= 3) begin
                            nm[c]  = nm[c] | (H'(x0 ^ x1 ^ x2) << nht[c]);
                            nht[c] = nht[c] + 1;
                            if (c + 1 < PC) begin
                                nm[c+1]  = nm[c+1] | (H'((x0 & x1) | (x0 & x2) | (x1 & x2)) << nht[c+1]);
                                nht[c+1] = nht[c+1] + 1;
                            end
                        end else if (ht[c] - g == 2) begin
                            nm[c]  = nm[c] | (H'(x0 ^ x1) << nht[c]);
                            nht[c] = nht[c] + 1;
                            if (c + 1 < PC) begin
                                nm[c+1]  = nm[c+1] | (H'(x0 & x1) << nht[c+1]);
                                nht[c+1] = nht[c+1] + 1;
                            end
                        end else if (ht[c] - g == 1) begin
                            nm[c]  = nm[c] | (H'(x0) << nht[c]);
                            nht[c] = nht[c] + 1;
                        end
                    end
                end
                for (int c = 0; c < PC; c++) begin
                    m[c]  = nm[c];
                    ht[c] = nht[c];
                end
            end
        end

        for (int c = 0; c < PC; c++) begin
            row_x[c] = m[c][0];
            row_y[c] = m[c][1];
        end
    end

    assign sum = row_x + row_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            prod    <= '0;
        end else begin
            out_vld <= op_vld;
            if (op_vld) prod <= sum;
        end
    end
endmodule

// File: tb/tb_wallace_gen.sv
// Self-checking bench for wallace_gen: exhaustive sweep, directed values, valid gating and async reset.
// Expected results come from plain signed integer multiplication truncated to N+W-1 bits.
module tb_wallace_gen;
    localparam int N  = 8;
    localparam int W  = 5;
    localparam int PW = N + W - 1;
`ifdef WALLACE_GEN_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_vld;
    logic [N-1:0]  a;
    logic [W-1:0]  b;
    logic          out_vld;
    logic [PW-1:0] prod;

    int total;
    int bad;

    logic [PW-1:0] exp_q [$];
    logic          expv_q [$];
    logic [PW-1:0] model_hold;
    logic          have;
    logic          ev;
    logic [PW-1:0] ep;

    wallace_gen #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (in_vld),
        .a      (a),
        .b      (b),
        .out_vld(out_vld),
        .prod   (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_prod(input logic [N-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint p;
        sx = longint'(x);
        if (x[N-1]) sx = sx - (longint'(1) << N);
        sy = longint'(y);
        if (y[W-1]) sy = sy - (longint'(1) << W);
        p = sx * sy;
        return p[PW-1:0];
    endfunction

    // Drives one cycle, updates the reference model, and exposes the output expected after this edge.
    task automatic step(input logic v, input logic [N-1:0] aa, input logic [W-1:0] bb);
        in_vld = v;
        a      = aa;
        b      = bb;
        if (v) model_hold = ref_prod(aa, bb);
        expv_q.push_back(v);
        exp_q.push_back(model_hold);
        @(posedge clk);
        #1;
        if (expv_q.size() >= LAT) begin
            have = 1'b1;
            ev   = expv_q.pop_front();
            ep   = exp_q.pop_front();
        end else begin
            have = 1'b0;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        expv_q.delete();
        model_hold = '0;
        have       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        in_vld = 1'b0;
        a      = '0;
        b      = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_vld got=%b want=0", out_vld);
        end
        total++;
        if (prod !== '0) begin
            bad++;
            $display("FAIL reset_prod got=%h want=000", prod);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [N-1:0]  ta [5];
        logic [W-1:0]  tbv [5];
        logic [PW-1:0] te [5];
        ta  = '{8'd5, 8'hFF, 8'hFD, 8'd127, 8'd127};
        tbv = '{5'd3, 5'd1, 5'h1B, 5'd15, 5'h10};
        te  = '{12'h00F, 12'hFFF, 12'h00F, 12'h771, 12'h810};
        for (int k = 0; k < 5; k++) begin
            step(1'b1, ta[k], tbv[k]);
            for (int f = 1; f < LAT; f++) step(1'b0, '0, '0);
            total++;
            if (out_vld !== 1'b1 || prod !== te[k]) begin
                bad++;
                $display("FAIL directed%0d a=%h b=%h got=%h/%b want=%h/1", k, ta[k], tbv[k], prod, out_vld, te[k]);
            end
        end
    endtask

    task automatic test_corner();
        logic [N-1:0]  ca;
        logic [W-1:0]  cb;
        logic [PW-1:0] ce;
        ca = '0;
        cb = '0;
        ce = '0;
        ca[N-1] = 1'b1;
        cb[W-1] = 1'b1;
        ce[PW-1] = 1'b1;
        step(1'b1, ca, cb);
        for (int f = 1; f < LAT; f++) step(1'b0, '0, '0);
        total++;
        if (out_vld !== 1'b1 || prod !== ce) begin
            bad++;
            $display("FAIL corner_wrap got=%h/%b want=%h/1", prod, out_vld, ce);
        end
    endtask

    task automatic test_sweep();
        logic [N-1:0] sa;
        logic [W-1:0] sb;
        int           errs;
        errs = 0;
        for (int k = 0; k < (1 << (N + W)); k++) begin
            sa = k[N-1:0];
            sb = k[N+W-1:N];
            step(1'b1, sa, sb);
            if (have) begin
                total++;
                if (out_vld !== ev || prod !== ep) begin
                    bad++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL sweep k=%0d got=%h/%b want=%h/%b", k, prod, out_vld, ep, ev);
                end
            end
        end
        for (int f = 1; f < LAT; f++) begin
            step(1'b0, '0, '0);
            total++;
            if (out_vld !== ev || prod !== ep) begin
                bad++;
                $display("FAIL sweep_tail got=%h/%b want=%h/%b", prod, out_vld, ep, ev);
            end
        end
    endtask

    task automatic test_gating();
        logic pat [3];
        pat = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3 + LAT - 1; k++) begin
            if (k < 3) step(pat[k], N'($urandom), W'($urandom));
            else step(1'b0, N'($urandom), W'($urandom));
            if (have) begin
                total++;
                if (out_vld !== ev || prod !== ep) begin
                    bad++;
                    $display("FAIL gating%0d got=%h/%b want=%h/%b", k, prod, out_vld, ep, ev);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 3) != 0), N'($urandom), W'($urandom));
            if (have) begin
                total++;
                if (out_vld !== ev || prod !== ep) begin
                    bad++;
                    $display("FAIL random%0d got=%h/%b want=%h/%b", k, prod, out_vld, ep, ev);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [N-1:0] ra;
        logic [W-1:0] rb;
        for (int k = 0; k < 4; k++) step(1'b1, N'($urandom_range(1, 100)), W'($urandom_range(1, 10)));
        total++;
        if (out_vld !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre_vld got=%b want=1", out_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_vld !== 1'b0) begin
            bad++;
            $display("FAIL midrst_vld got=%b want=0", out_vld);
        end
        total++;
        if (prod !== '0) begin
            bad++;
            $display("FAIL midrst_prod got=%h want=000", prod);
        end
        in_vld = 1'b0;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, '0);
        total++;
        if (out_vld !== 1'b0 || prod !== '0) begin
            bad++;
            $display("FAIL midrst_idle got=%h/%b want=000/0", prod, out_vld);
        end
        ra = N'($urandom);
        rb = W'($urandom);
        step(1'b1, ra, rb);
        for (int f = 1; f < LAT; f++) begin
            total++;
            if (out_vld !== 1'b0) begin
                bad++;
                $display("FAIL midrst_early got=%b want=0", out_vld);
            end
            step(1'b0, '0, '0);
        end
        total++;
        if (out_vld !== 1'b1 || prod !== ref_prod(ra, rb)) begin
            bad++;
            $display("FAIL midrst_first got=%h/%b want=%h/1", prod, out_vld, ref_prod(ra, rb));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_corner();
        test_gating();
        test_sweep();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
